// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
// Holds the FSM state encoding, iteration count and product width.
// Also carries the 32-bit magnitude helper used by the signed build.
package mult_pkg;

  localparam int MULT_ITER = 32;
  localparam int PROD_W    = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Magnitude of a 32-bit operand; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude of -2^31.
  function automatic logic [31:0] abs32(input logic [31:0] x, input logic sgn);
    abs32 = (sgn && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/adder.sv
// 64-bit adder split into 32-bit halves with carry rippling low to high.
// Latency: combinational, result valid in the same cycle as the operands.
// Backpressure: none; a pure function of its inputs.
module adder (
  input  logic [31:0] operand1_H,
  input  logic [31:0] operand1_L,
  input  logic [31:0] operand2_H,
  input  logic [31:0] operand2_L,
  input  logic        cin,
  output logic [31:0] result_H,
  output logic [31:0] result_L,
  output logic        cout
);

  logic [32:0] sum_lo;
  logic [32:0] sum_hi;

  // Low half first; its carry feeds the high half.
  always_comb begin
    sum_lo   = {1'b0, operand1_L} + {1'b0, operand2_L} + {32'd0, cin};
    sum_hi   = {1'b0, operand1_H} + {1'b0, operand2_H} + {32'd0, sum_lo[32]};
    result_L = sum_lo[31:0];
    result_H = sum_hi[31:0];
    cout     = sum_hi[32];
  end

endmodule

// File: rtl/multiply.sv
// 32x32->64 shift-and-add multiplier, one multiplier bit per clock.
// Latency: done pulses 32 cycles after the start edge (33 with MULT_SIGNED_EN).
// Backpressure: start is only accepted in IDLE; requests while busy are dropped.
module multiply
  import mult_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mult_signed,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product_H,
  output logic [31:0] product_L
);

  localparam logic [4:0] LAST_CNT = 5'(MULT_ITER - 1);

  state_e              state_q, state_d;
  logic [PROD_W-1:0]   mcand_q, mcand_d;
  logic [31:0]         mplier_q, mplier_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [4:0]          count_q, count_d;

  logic [31:0]         a_mag, b_mag;
  logic [PROD_W-1:0]   add_op1, add_op2;
  logic                add_cin;
  logic [31:0]         add_res_H, add_res_L;
  logic                cout_unused;

`ifdef MULT_SIGNED_EN
  logic                neg_q, neg_d;
  logic                neg_start;

  // Signed build: operate on magnitudes and remember the result sign.
  always_comb begin
    a_mag     = abs32(op_a, mult_signed);
    b_mag     = abs32(op_b, mult_signed);
    neg_start = mult_signed & (op_a[31] ^ op_b[31]);
  end
`else
  logic                mult_signed_unused;

  // Unsigned-only build: operands pass straight through.
  always_comb begin
    a_mag              = op_a;
    b_mag              = op_b;
    mult_signed_unused = mult_signed;
  end
`endif

  // Single shared adder; operands are muxed by state in the FSM below.
  adder u_adder (
    .operand1_H (add_op1[63:32]),
    .operand1_L (add_op1[31:0]),
    .operand2_H (add_op2[63:32]),
    .operand2_L (add_op2[31:0]),
    .cin        (add_cin),
    .result_H   (add_res_H),
    .result_L   (add_res_L),
    .cout       (cout_unused)
  );

  // Next-state, datapath updates and adder operand selection.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    add_op1  = acc_q;
    add_op2  = mcand_q;
    add_cin  = 1'b0;
`ifdef MULT_SIGNED_EN
    neg_d    = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {32'd0, a_mag};
          mplier_d = b_mag;
          acc_d    = '0;
          count_d  = 5'd0;
`ifdef MULT_SIGNED_EN
          neg_d    = neg_start;
`endif
          state_d  = RUN;
        end
      end
      RUN: begin
        if (mplier_q[0]) begin
          acc_d = {add_res_H, add_res_L};
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 5'd1;
        if (count_q == LAST_CNT) begin
`ifdef MULT_SIGNED_EN
          state_d = NEG;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef MULT_SIGNED_EN
      NEG: begin
        // Two's-complement negate through the same adder: ~acc + 0 + 1.
        add_op1 = ~acc_q;
        add_op2 = '0;
        add_cin = 1'b1;
        if (neg_q) begin
          acc_d = {add_res_H, add_res_L};
        end
        state_d = DONE;
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
`ifdef MULT_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
`ifdef MULT_SIGNED_EN
      neg_q    <= neg_d;
`endif
    end
  end

  // Status decodes from state; product is the accumulator itself.
  always_comb begin
    busy      = (state_q == RUN) || (state_q == NEG);
    done      = (state_q == DONE);
    product_H = acc_q[63:32];
    product_L = acc_q[31:0];
  end

endmodule

// File: tb/tb_multiply.sv
module tb_multiply;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mult_signed;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] product_H;
  logic [31:0] product_L;

  int checks = 0;
  int errors = 0;

`ifdef MULT_SIGNED_EN
  localparam int LAT    = 33;
  localparam bit SGN_EN = 1'b1;
`else
  localparam int LAT    = 32;
  localparam bit SGN_EN = 1'b0;
`endif

  multiply dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mult_signed (mult_signed),
    .op_a        (op_a),
    .op_b        (op_b),
    .busy        (busy),
    .done        (done),
    .product_H   (product_H),
    .product_L   (product_L)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [63:0] exp_u;
    logic [63:0] exp_s;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Launch one operation and follow it to completion (or to a mid-run reset).
  // inj_k: observation index at which a second start is pulsed (-1 = none).
  // rst_k: observation index at which rst is asserted (-1 = none).
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input logic [63:0] exp,
                        input int inj_k, input int rst_k);
    int  k;
    bit  busy_ok;
    @(negedge clk);
    op_a = a; op_b = b; mult_signed = sgn; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op_a  = ~a;
    op_b  = ~b;
    mult_signed = ~sgn;
    k = 0;
    busy_ok = busy;
    while (!done && k < 200) begin
      if (k == inj_k) begin
        start = 1'b1; op_a = 32'h0000_DEAD; op_b = 32'h0000_0077; mult_signed = 1'b0;
      end
      if (k == rst_k) rst = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (rst) begin
        rst = 1'b0;
        chk({name, "_rst_busy"}, 64'(busy), 64'd0);
        chk({name, "_rst_done"}, 64'(done), 64'd0);
        chk({name, "_rst_prod"}, {product_H, product_L}, 64'd0);
        return;
      end
      k++;
      if (!done && !busy) busy_ok = 1'b0;
    end
    chk({name, "_latency"}, 64'(k), 64'(LAT));
    chk({name, "_busy_run"}, 64'(busy_ok), 64'd1);
    chk({name, "_prod"}, {product_H, product_L}, exp);
    chk({name, "_busy_done"}, 64'(busy), 64'd0);
    @(negedge clk);
    chk({name, "_done_1cyc"}, 64'(done), 64'd0);
    chk({name, "_idle_after"}, 64'(busy), 64'd0);
  endtask

  task automatic hold_check(input string name, input logic [63:0] exp);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("%s_hold%0d", name, i), {product_H, product_L}, exp);
    end
  endtask

  initial begin
    logic [63:0] e;

    vecs[0] = '{32'd3,         32'd5,         1'b0, 64'h0000_0000_0000_000F, 64'h0000_0000_0000_000F};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'hFFFF_FFFD, 32'd5,         1'b1, 64'h0000_0004_FFFF_FFF1, 64'hFFFF_FFFF_FFFF_FFF1};
    vecs[3] = '{32'h8000_0000, 32'd1,         1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_8000_0000};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001, 64'h0000_0000_0000_0001};
    vecs[6] = '{32'd7,         32'hFFFF_FFFE, 1'b1, 64'h0000_0006_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFF2};
    vecs[7] = '{32'hFFFF_FFFB, 32'hFFFF_FFFA, 1'b1, 64'hFFFF_FFF5_0000_001E, 64'h0000_0000_0000_001E};

    rst = 1'b1; start = 1'b0; mult_signed = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_prod", {product_H, product_L}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      e = (vecs[i].sgn && SGN_EN) ? vecs[i].exp_s : vecs[i].exp_u;
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn, e, -1, -1);
    end

    // Second start mid-run is dropped; result and single done unaffected.
    run_op("inject", 32'h0000_1234, 32'h0000_0010, 1'b0, 64'h0000_0000_0001_2340, 5, -1);

    // Reset mid-run, then a fresh operation runs with full latency.
    run_op("midrst", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'd0, -1, 10);
    run_op("after_rst", 32'd7, 32'd6, 1'b0, 64'h0000_0000_0000_002A, -1, -1);
    hold_check("hold42", 64'h0000_0000_0000_002A);

    // Zero operand still takes full latency; result then held.
    run_op("zero", 32'd0, 32'h1234_5678, 1'b0, 64'd0, -1, -1);
    hold_check("hold0", 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiply.md
# multiply

Multi-cycle shift-and-add multiplier: 32×32→64-bit product computed one multiplier bit per clock. Sits directly upstream of the 64-bit split-half adder, which it instantiates and drives with a partial-product accumulator (operand1), a shifted multiplicand (operand2) and a carry-in, consuming its result_H/result_L each cycle. The result is presented in the same H/L halves the adder uses.

## Interface
- No parameters. Width is fixed at 32×32→64 to match the adder.
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- mult_signed  in  1  1 = two's-complement operands; sampled with start; ignored without MULT_SIGNED_EN
- op_a  in  32  multiplicand; sampled with start
- op_b  in  32  multiplier; sampled with start
- busy  out  1  high in RUN and NEG
- done  out  1  one-cycle pulse in DONE; product valid
- product_H  out  32  product bits [63:32]
- product_L  out  32  product bits [31:0]

## Operation
- Registers: mcand (64), mplier (32), acc (64), count (5), neg (1), state.
- IDLE: if start, load mcand = {32'b0, |op_a|}, mplier = |op_b|, acc = 0, count = 0, neg = signed & (op_a[31] ^ op_b[31]); go to RUN. |x| = x when unsigned or x[31]=0, else ~x+1 (32-bit; 0x80000000 maps to itself, which is correct as unsigned).
- RUN, each cycle: if mplier[0], acc <= adder result (operand1 = acc, operand2 = mcand, cin = 0); else acc holds. mcand <<= 1, mplier >>= 1, count++. When count == 31, go to NEG with macro, else DONE.
- NEG: if neg, acc <= ~acc + 1 through the adder (operand1 = ~acc, operand2 = 0, cin = 1); else acc holds. Go to DONE.
- DONE: done = 1; go to IDLE.
- Adder cout is ignored; the 64-bit product cannot overflow.
- product_H/L drive acc directly. Final value is valid from DONE and held until the next accepted start clears acc.
- start in RUN, NEG or DONE is ignored (not queued). Operand changes after the sampling edge have no effect.
- Zero operands still take the full iteration count. There is no early termination.

## Timing
- Reset values: state = IDLE, busy = 0, done = 0, product_H = 0, product_L = 0; all internal registers 0.
- rst asserted in any state, including mid-RUN, returns to IDLE on the next edge, discards the operation and zeroes the outputs. rst has priority over start.
- Let start be sampled at edge E.
  - busy rises after E.
  - Without the macro, done is high in the cycle following edge E+32: 32 RUN iterations.
  - With the macro, done is high in the cycle following edge E+33.
- done lasts exactly one cycle. busy is low during DONE.
- Earliest next start is sampled at the edge leaving DONE+1, i.e. in IDLE. Back-to-back throughput is one result per 34 cycles unsigned, 35 signed.

## Configuration
- MULT_SIGNED_EN
  - Defined: operand absolute-value logic, the neg flag and the NEG state are compiled in, and mult_signed selects signed or unsigned.
  - Undefined: unsigned only, no NEG state, mult_signed unconnected internally, latency 32.

## Structure
- Shared package `mult_pkg`:
  - state encoding typedef (IDLE, RUN, NEG, DONE)
  - constant MULT_ITER = 32
  - constant PROD_W = 64
- One sub-module: the existing 64-bit adder `adder`, with ports operand1_H/L, operand2_H/L, cin, result_H/L, cout. It is instantiated once and muxed between the RUN and NEG operand selections. No second adder instance.

## Test plan
- Unsigned 3 × 5 (op_a=3, op_b=5, mult_signed=0) -> product_H=0, product_L=0x0000000F; done exactly 32 cycles after start edge (33 with macro); busy high throughout.
- Unsigned 0xFFFFFFFF × 0xFFFFFFFF -> product_H=0xFFFFFFFE, product_L=0x00000001.
- Signed, macro on:
  - 0xFFFFFFFD × 5 -> product_H=0xFFFFFFFF, product_L=0xFFFFFFF1.
  - 0x80000000 × 1 -> product_H=0xFFFFFFFF, product_L=0x80000000.
  - 0x80000000 × 0x80000000 -> product_H=0x40000000, product_L=0.
- start pulsed again at RUN cycle 5 with different operands -> ignored; first result unchanged; single done pulse.
- rst asserted at RUN cycle 10 -> next cycle busy=0, done=0, product=0; a following start with 7 × 6 gives product_L=0x2A with full latency.
- 0 × 0x12345678 -> product 0; latency unchanged. After done, product held stable for 20 idle cycles.
